fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n  input  1  SHALL be the reset; asynchronous, active-low.
REQ-004 Port stall  input  1  SHALL mean decode cannot accept a new IF/ID entry this cycle.
REQ-005 Port branch_taken  input  1  SHALL mean a beq resolved taken; one-cycle pulse.
REQ-006 Port branch_target  input  32  SHALL be the redirect byte address, valid with branch_taken.
REQ-007 Port imem_req  output  1  SHALL mean an instruction-memory read is outstanding.
REQ-008 Port imem_addr  output  32  SHALL be the word-aligned read address.
REQ-009 Port imem_ack  input  1  SHALL mean imem_rdata is valid and the request completes.
REQ-010 Port imem_rdata  input  32  SHALL be the returned instruction.
REQ-011 Port ifid_valid  output  1  SHALL mean the IF/ID register holds a live instruction.
REQ-012 Port ifid_instr  output  32  SHALL be the IF/ID instruction.
REQ-013 Port ifid_opcode  output  6  SHALL equal ifid_instr[31:26]; it drives the control unit's opcode input.
REQ-014 Port ifid_pc4  output  32  SHALL be the fetch address of ifid_instr plus 4.

Function
REQ-015 FSM states SHALL be REQ (request outstanding), SQUASH (outstanding request whose response is discarded), HOLD (response parked, no request).
REQ-016 imem_req SHALL be 1 in REQ and SQUASH and 0 in HOLD; imem_addr SHALL stay stable from request until imem_ack.
REQ-017 REQ, imem_ack, no branch: if !ifid_valid or !stall, the response loads IF/ID (valid=1, pc4=imem_addr+4), pc+=4, and the next request issues the following cycle (one-cycle latency per fetch).
REQ-018 REQ, imem_ack, stall with ifid_valid=1: the response SHALL load a one-entry skid buffer; state goes to HOLD; pc+=4.
REQ-019 HOLD, stall=0: skid buffer SHALL move into IF/ID; state goes to REQ.
REQ-020 With stall=0 and no new load, ifid_valid SHALL clear the next cycle (entry consumed).
REQ-021 branch_taken SHALL have priority over stall and imem_ack: pc<=branch_target, ifid_valid<=0, skid cleared.
REQ-022 branch_taken in REQ without imem_ack: state goes to SQUASH; the pending response is dropped on its ack, then state goes to REQ fetching branch_target.
REQ-023 branch_taken coincident with imem_ack, or in HOLD: that data SHALL be discarded; state goes to REQ at branch_target the next cycle.
REQ-024 branch_taken in SQUASH SHALL overwrite the pending target; only the latest target is fetched.
REQ-025 pc arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0; imem_addr[1:0] SHALL be 2'b00.

Reset
REQ-026 While rst_n=0: pc=RESET_PC, state=REQ, ifid_valid=0, ifid_instr=0, ifid_pc4=0, skid empty, counters 0.
REQ-027 imem_req SHALL be 0 during reset and 1 from the first clock edge after deassertion; reset mid-request abandons it, and a late imem_ack while rst_n=0 is ignored.

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN defined: outputs perf_fetch_cnt[31:0] (accepted responses into IF/ID or skid) and perf_stall_cnt[31:0] (cycles with imem_req=1 and imem_ack=0), wrapping modulo 2^32. Undefined: neither port nor counter exists.

Structure
REQ-029 Shared package mips_pkg SHALL hold the fetch FSM state enum, the opcode width (6), OP_BEQ=6'h04, and INSTR_W=32.
REQ-030 One sub-module, fetch_skid_buf (one-entry instr/pc4 buffer with load/drain/clear), SHALL be instantiated.

Verification
REQ-031 Reset release, imem_ack one cycle after each request, stall=0 -> imem_addr 0,4,8; ifid_pc4 4,8,12; ifid_opcode tracks instr[31:26].
REQ-032 ifid_valid=1, stall held 3 cycles, ack arrives -> HOLD, imem_req=0; stall drop -> skid word in IF/ID next cycle, then fetch at next pc.
REQ-033 branch_taken (target 32'h40) during an outstanding request, ack 2 cycles later -> that data never reaches IF/ID; next imem_addr=32'h40.
REQ-034 branch_taken with imem_ack and stall in the same cycle -> ifid_valid=0 next cycle; next fetch at target.
REQ-035 pc=32'hFFFF_FFFC fetched -> ifid_pc4=0, next imem_addr=0.
REQ-036 rst_n asserted mid-request -> outputs reset values immediately; with FETCH_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the fetch stage and its skid buffer.
//   INSTR_W        instruction / address width (32)
//   OPCODE_W       opcode field width (6)
//   OP_BEQ         beq opcode (6'h04)
//   fetch_state_e  fetch FSM states
//   next_pc()      32-bit modulo sequential-address increment
package mips_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;
  localparam logic [OPCODE_W-1:0] OP_BEQ = 6'h04;

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,  // request outstanding
    ST_SQUASH = 2'd1,  // request outstanding, its response will be dropped
    ST_HOLD   = 2'd2   // response parked in the skid buffer, no request
  } fetch_state_e;

  function automatic logic [INSTR_W-1:0] next_pc(input logic [INSTR_W-1:0] pc);
    return pc + 32'd4;  // wraps 32'hFFFF_FFFC -> 32'h0000_0000
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry buffer holding an instruction and its pc+4 while
// decode is stalled.
//   clk, rst_n        clock, async active-low reset
//   load_i            capture instr_i / pc4_i (entry becomes valid)
//   drain_i           entry moved downstream (entry becomes empty)
//   clear_i           flush; has priority over load and drain
//   valid_o, instr_o, pc4_o   buffered entry
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               drain_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [INSTR_W-1:0] pc4_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [INSTR_W-1:0] pc4_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] pc4_q;

  // Entry storage: clear wins, then load, then drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0000_0000;
      pc4_q   <= 32'h0000_0000;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with IF/ID register, one-entry skid buffer and
// branch redirect/squash handling.
//   RESET_PC                  first fetch address after reset
//   clk, rst_n                clock, async active-low reset
//   stall                     decode cannot accept a new IF/ID entry
//   branch_taken/_target      redirect pulse and byte address
//   imem_req/addr/ack/rdata   instruction-memory request/response
//   ifid_valid/instr/opcode/pc4   IF/ID register
// Optional macro FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [31:0]         branch_target,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                ifid_valid,
  output logic [INSTR_W-1:0]  ifid_instr,
  output logic [OPCODE_W-1:0] ifid_opcode,
  output logic [31:0]         ifid_pc4
`ifdef FETCH_PERF_CNT_EN
  , output logic [31:0]       perf_fetch_cnt
  , output logic [31:0]       perf_stall_cnt
`endif
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;      // address of the outstanding/next fetch
  logic [31:0]        tgt_q, tgt_d;    // redirect target held while squashing
  logic               req_q, req_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [31:0]        ifid_pc4_q, ifid_pc4_d;
  logic               ack_s;
  logic               skid_load_s, skid_drain_s, skid_clear_s;
  logic               skid_valid_s;
  logic [INSTR_W-1:0] skid_instr_s, skid_pc4_s;

  // An ack only counts against a request we actually issued (not the idle
  // cycle right after reset).
  assign ack_s = imem_ack & req_q;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load_s),
    .drain_i (skid_drain_s),
    .clear_i (skid_clear_s),
    .instr_i (imem_rdata),
    .pc4_i   (next_pc(pc_q)),
    .valid_o (skid_valid_s),
    .instr_o (skid_instr_s),
    .pc4_o   (skid_pc4_s)
  );

  // Next-state logic for the FSM, fetch pc and IF/ID register.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    ifid_valid_d = stall ? ifid_valid_q : 1'b0;  // unstalled entry is consumed
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    skid_load_s  = 1'b0;
    skid_drain_s = 1'b0;
    skid_clear_s = 1'b0;
    if (branch_taken) begin
      ifid_valid_d = 1'b0;
      skid_clear_s = 1'b1;
      // imem_addr must not move while a request is still outstanding, so the
      // target waits in tgt_q until the stale response is absorbed.
      if (req_q && !imem_ack) begin
        state_d = ST_SQUASH;
        tgt_d   = branch_target & 32'hFFFF_FFFC;
      end else begin
        state_d = ST_REQ;
        pc_d    = branch_target & 32'hFFFF_FFFC;
      end
    end else begin
      case (state_q)
        ST_REQ: begin
          if (ack_s) begin
            pc_d = next_pc(pc_q);
            if (!ifid_valid_q || !stall) begin
              ifid_valid_d = 1'b1;
              ifid_instr_d = imem_rdata;
              ifid_pc4_d   = next_pc(pc_q);
            end else begin
              skid_load_s = 1'b1;
              state_d     = ST_HOLD;
            end
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_SQUASH: begin
          if (ack_s) begin
            state_d = ST_REQ;
            pc_d    = tgt_q;
          end else begin
            state_d = ST_SQUASH;
          end
        end
        ST_HOLD: begin
          if (!stall && skid_valid_s) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = skid_instr_s;
            ifid_pc4_d   = skid_pc4_s;
            skid_drain_s = 1'b1;
            state_d      = ST_REQ;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_REQ;
        end
      endcase
    end
    req_d = (state_d != ST_HOLD);
  end

  // FSM state, fetch pc and IF/ID register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      tgt_q        <= 32'h0000_0000;
      req_q        <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= 32'h0000_0000;
      ifid_pc4_q   <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      req_q        <= req_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign ifid_valid  = ifid_valid_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_opcode = ifid_instr_q[31:26];
  assign ifid_pc4    = ifid_pc4_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  logic        fetch_inc_s;

  // A response is accepted when it lands in IF/ID or in the skid buffer.
  assign fetch_inc_s = ack_s & ~branch_taken & (state_q == ST_REQ);

  // Performance counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0000_0000;
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + {31'd0, fetch_inc_s};
      stall_cnt_q <= stall_cnt_q + {31'd0, (req_q & ~imem_ack)};
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [5:0]  ifid_opcode;
  logic [31:0] ifid_pc4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int total;
  int passed;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_opcode   (ifid_opcode),
    .ifid_pc4      (ifid_pc4)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_cnt (perf_fetch_cnt)
    , .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as a pure function of the byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Reset, release, and return at the negedge after the first active edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %0h expected 0", imem_req); else passed++;
    total++; if (ifid_valid !== 1'b0) $display("FAIL rst_valid: got %0h expected 0", ifid_valid); else passed++;
    total++; if (ifid_instr !== 32'd0 || ifid_pc4 !== 32'd0)
      $display("FAIL rst_ifid: got instr %0h pc4 %0h expected 0 0", ifid_instr, ifid_pc4); else passed++;
    total++; if (imem_addr !== 32'd0) $display("FAIL rst_addr: got %0h expected 0", imem_addr); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL rel_req_before_edge: got %0h expected 0", imem_req); else passed++;
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'd0)
      $display("FAIL first_req: got req %0h addr %0h expected 1 0", imem_req, imem_addr); else passed++;
  endtask

  // Ack one cycle after each request, no stall: addresses 0,4,8 and pc4 4,8,12.
  task automatic test_sequential();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k))
          $display("FAIL seq_addr%0d: got req %0h addr %0h expected 1 %0h", k, imem_req, imem_addr, 4 * k); else passed++;
      end
      if (k > 0) begin
        total++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'(4 * k) || ifid_instr !== mem_word(32'(4 * (k - 1))))
          $display("FAIL seq_ifid%0d: got v %0h pc4 %0h instr %0h expected 1 %0h %0h", k, ifid_valid, ifid_pc4,
                   ifid_instr, 4 * k, mem_word(32'(4 * (k - 1)))); else passed++;
        total++; if (ifid_opcode !== ifid_instr[31:26])
          $display("FAIL seq_opcode%0d: got %0h expected %0h", k, ifid_opcode, ifid_instr[31:26]); else passed++;
      end
      imem_ack = imem_req; imem_rdata = mem_word(imem_addr);
      @(negedge clk);
    end
    imem_ack = 1'b0;
  endtask

  // Stall while IF/ID is full and the ack arrives: response parks, request stops.
  task automatic test_stall_hold();
    do_reset();
    imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);   // word 0 -> IF/ID
    @(negedge clk);
    stall = 1'b1; imem_ack = 1'b0;                        // stall cycle 1
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);   // stall cycle 2, ack of word 4
    @(negedge clk);
    imem_ack = 1'b0;
    total++; if (imem_req !== 1'b0 || ifid_valid !== 1'b1 || ifid_pc4 !== 32'd4)
      $display("FAIL hold_enter: got req %0h v %0h pc4 %0h expected 0 1 4", imem_req, ifid_valid, ifid_pc4); else passed++;
    @(negedge clk);                                       // stall cycle 3
    total++; if (imem_req !== 1'b0) $display("FAIL hold_req: got %0h expected 0", imem_req); else passed++;
    stall = 1'b0;
    @(negedge clk);
    total++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'd8 || ifid_instr !== mem_word(32'd4))
      $display("FAIL hold_drain: got v %0h pc4 %0h instr %0h expected 1 8 %0h", ifid_valid, ifid_pc4, ifid_instr,
               mem_word(32'd4)); else passed++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'd8)
      $display("FAIL hold_next_req: got req %0h addr %0h expected 1 8", imem_req, imem_addr); else passed++;
  endtask

  // Branch while a request is outstanding: late response must be dropped.
  task automatic test_branch_squash();
    do_reset();
    branch_taken = 1'b1; branch_target = 32'h40;
    @(negedge clk);
    branch_taken = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'd0)
      $display("FAIL squash_addr_stable: got req %0h addr %0h expected 1 0", imem_req, imem_addr); else passed++;
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
    @(negedge clk);
    total++; if (ifid_valid !== 1'b0) $display("FAIL squash_drop: got valid %0h expected 0", ifid_valid); else passed++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40)
      $display("FAIL squash_target: got req %0h addr %0h expected 1 40", imem_req, imem_addr); else passed++;
    imem_rdata = mem_word(imem_addr);
    @(negedge clk);
    imem_ack = 1'b0;
    total++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h44 || ifid_instr !== mem_word(32'h40))
      $display("FAIL squash_fetch: got v %0h pc4 %0h instr %0h expected 1 44 %0h", ifid_valid, ifid_pc4, ifid_instr,
               mem_word(32'h40)); else passed++;
  endtask

  // Branch together with ack and stall: IF/ID flushed, fetch at target.
  task automatic test_branch_ack_stall();
    do_reset();
    imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
    @(negedge clk);
    branch_taken = 1'b1; branch_target = 32'h80; stall = 1'b1; imem_rdata = mem_word(imem_addr);
    @(negedge clk);
    branch_taken = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    total++; if (ifid_valid !== 1'b0) $display("FAIL bas_valid: got %0h expected 0", ifid_valid); else passed++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h80)
      $display("FAIL bas_target: got req %0h addr %0h expected 1 80", imem_req, imem_addr); else passed++;
  endtask

  // Fetch at the top of the address space wraps to 0.
  task automatic test_wrap();
    do_reset();
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    @(negedge clk);
    branch_taken = 1'b0; imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
    @(negedge clk);
    total++; if (imem_addr !== 32'hFFFF_FFFC)
      $display("FAIL wrap_addr: got %0h expected fffffffc", imem_addr); else passed++;
    imem_rdata = mem_word(imem_addr);
    @(negedge clk);
    imem_ack = 1'b0;
    total++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'd0 || ifid_instr !== mem_word(32'hFFFF_FFFC))
      $display("FAIL wrap_pc4: got v %0h pc4 %0h instr %0h expected 1 0 %0h", ifid_valid, ifid_pc4, ifid_instr,
               mem_word(32'hFFFF_FFFC)); else passed++;
    total++; if (imem_addr !== 32'd0) $display("FAIL wrap_next: got %0h expected 0", imem_addr); else passed++;
  endtask

  // Reset asserted with a live IF/ID entry and a request outstanding.
  task automatic test_reset_mid();
    do_reset();
    imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
    @(negedge clk);
    imem_ack = 1'b0; stall = 1'b1;
    @(negedge clk);
    rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    total++; if (imem_req !== 1'b0 || ifid_valid !== 1'b0 || ifid_instr !== 32'd0 || ifid_pc4 !== 32'd0 || imem_addr !== 32'd0)
      $display("FAIL rstmid_now: got req %0h v %0h instr %0h pc4 %0h addr %0h expected all 0",
               imem_req, ifid_valid, ifid_instr, ifid_pc4, imem_addr); else passed++;
`ifdef FETCH_PERF_CNT_EN
    total++; if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0)
      $display("FAIL rstmid_cnt: got %0h %0h expected 0 0", perf_fetch_cnt, perf_stall_cnt); else passed++;
`endif
    @(negedge clk);                                       // late ack while in reset
    total++; if (imem_req !== 1'b0 || ifid_valid !== 1'b0)
      $display("FAIL rstmid_ack_ignored: got req %0h v %0h expected 0 0", imem_req, ifid_valid); else passed++;
    imem_ack = 1'b0; stall = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'd0)
      $display("FAIL rstmid_restart: got req %0h addr %0h expected 1 0", imem_req, imem_addr); else passed++;
  endtask

  // Random stall/ack/branch traffic checked against the program-order model:
  // every instruction decode takes must be the next one in program flow.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic        prev_pending;
    logic [31:0] prev_addr;
    int          consumed;
    logic        br;
    do_reset();
    exp_pc = 32'd0; prev_pending = 1'b0; prev_addr = 32'd0; consumed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_pending) begin
        total++; if (imem_addr !== prev_addr)
          $display("FAIL rnd_addr_stable: got %0h expected %0h (cycle %0d)", imem_addr, prev_addr, cyc); else passed++;
      end
      total++; if (imem_addr[1:0] !== 2'b00)
        $display("FAIL rnd_align: got %0h expected 0 (cycle %0d)", imem_addr[1:0], cyc); else passed++;
      br = ($urandom_range(0, 15) == 0);
      branch_taken = br;
      branch_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      stall = ($urandom_range(0, 2) == 0);
      imem_ack = imem_req && ($urandom_range(0, 2) != 0);
      imem_rdata = mem_word(imem_addr);
      if (!br && ifid_valid && !stall) begin
        total++; if (ifid_instr !== mem_word(exp_pc) || ifid_pc4 !== exp_pc + 32'd4 || ifid_opcode !== ifid_instr[31:26])
          $display("FAIL rnd_consume: got instr %0h pc4 %0h op %0h expected %0h %0h %0h (cycle %0d)", ifid_instr, ifid_pc4,
                   ifid_opcode, mem_word(exp_pc), exp_pc + 32'd4, mem_word(exp_pc) >> 26, cyc); else passed++;
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (br) exp_pc = branch_target;
      prev_pending = imem_req && !imem_ack;
      prev_addr = imem_addr;
      @(negedge clk);
    end
    branch_taken = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    total++; if (consumed < 200)
      $display("FAIL rnd_progress: got %0d consumed expected at least 200", consumed); else passed++;
  endtask

  initial begin
    total = 0; passed = 0;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    test_reset();
    test_sequential();
    test_stall_hold();
    test_branch_squash();
    test_branch_ack_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
